reorder_buffer_p: RTL
=====================

// Module: reorder_buffer_p
// PURPOSE
//  Parametrised reorder buffer: allocates in-order entries from the decoder, captures results from NCDB
//  broadcast buses, and retires one ready entry per cycle, in order, to the register file.
//  Two combinational operand lookups serve the decoder, with CDB bypass.
//  Sits between decoder/dispatch, the execution CDBs and the architectural register file.
// PARAMETERS
//  DEPTH   16  entries; power of 2, >=2
//  IDX_W   4   $clog2(DEPTH); entry index width
//  DATA_W  32  result width
//  REG_W   5   destination register index width
//  NCDB    3   number of CDB write ports (0=ALU, 1=branch, 2=LS buffer)
// PORTS
//  clk            in   1              clock
//  rst            in   1              synchronous reset, active-high
//  alloc_valid    in   1              decoder requests an entry
//  alloc_rd       in   REG_W          destination register of the new entry
//  alloc_ready    out  1              count < DEPTH
//  alloc_tag      out  IDX_W+1        {1'b0, tail}; tag given to the new entry
//  src1_tag       in   IDX_W+1        operand 1 tag; MSB=1 (TAG_FREE) means no producer
//  src2_tag       in   IDX_W+1        operand 2 tag
//  src1_ready     out  1              operand 1 value available
//  src1_data      out  DATA_W         operand 1 value
//  src2_ready     out  1              operand 2 value available
//  src2_data      out  DATA_W         operand 2 value
//  cdb_valid      in   NCDB           per-port write strobe
//  cdb_tag        in   NCDB*(IDX_W+1) port p at [p*(IDX_W+1) +: IDX_W+1]
//  cdb_data       in   NCDB*DATA_W    port p at [p*DATA_W +: DATA_W]
//  cdb_mispredict in   NCDB           result is a mispredicted branch (used only with ROB_FLUSH_EN)
//  commit_valid   out  1              registered; one entry retired
//  commit_rd      out  REG_W          retired destination register
//  commit_data    out  DATA_W         retired value
//  commit_tag     out  IDX_W+1        retired tag (register file clears its rename if the tag matches)
//  flush          out  1              registered misprediction flush pulse
//  flush_pc       out  DATA_W         redirect target (data of the mispredicted entry)
//  rob_count      out  IDX_W+1        occupied entries
// BEHAVIOUR
//  Reset: head=tail=count=0; all entry valid/ready bits=0; commit_*, flush, flush_pc = 0; alloc_ready=1.
//  Allocate: on alloc_valid & alloc_ready, entry[tail] <= {valid=1, ready=0, rd, data=0}; tail <= tail+1 mod DEPTH.
//   alloc_valid while full is ignored; no state change.
//  alloc_ready depends on count only; a same-cycle retire does not free a slot for a same-cycle allocate.
//  CDB write: for each p with cdb_valid[p], tag MSB=0 and entry valid: set ready, store data. Writes land at the edge.
//   Two ports with the same tag in one cycle is illegal; the lowest p wins.
//  Lookup (combinational), priority: TAG_FREE -> ready=1, data=0; else matching valid CDB port (lowest p)
//   -> ready=1, that port's data; else the stored entry ready/data.
//  Retire: when count!=0 and entry[head].ready, at the edge: commit_valid<=1 with rd/data/tag; entry invalidated;
//   head <= head+1. Otherwise commit_valid<=0.
//   Latency: CDB write at edge N -> retire at edge N+1 -> commit_valid high in the cycle after N+1.
//  Simultaneous allocate and retire: count unchanged; both pointers advance.
//  Wrap-around: pointers are IDX_W bits and wrap naturally. Full is count==DEPTH; empty is count==0.
//  rst asserted mid-operation discards all entries in one cycle; no retire occurs at that edge.
// CONFIGURATION
//  ROB_FLUSH_EN defined: each entry holds a mispredict bit, captured from cdb_mispredict on its CDB write.
//   Retiring such an entry: normal commit, plus flush<=1 and flush_pc<=its data for one cycle.
//   All entries are invalidated; head=tail=count=0. Any allocate in that same cycle is dropped.
//  ROB_FLUSH_EN undefined: cdb_mispredict ignored; flush=0 and flush_pc=0 constantly; no mispredict storage.
// STRUCTURE
//  Shared defines header: ROB tag width, TAG_FREE encoding (MSB set), entry field ranges {valid, ready, mispred, rd, data}.
//  Sub-module rob_src_lookup: tag + CDB vectors + stored ready/data -> ready/data; instantiated twice (src1, src2).
// TESTING
//  Reset, then 16 allocs with no CDB -> alloc_tag 0..15, alloc_ready=0 after the 16th, rob_count=16; 17th ignored.
//  Tags 0,1,2 allocated; CDB writes tag1=0x11, then tag0=0x10 -> commits in order 0 (0x10), then 1 (0x11); tag2 held.
//  CDB p0 and p2 both write tag3 in one cycle (0xA, 0xB) -> entry holds 0xA.
//  src1_tag=5 while CDB p1 broadcasts tag5=0x55 -> same cycle src1_ready=1, src1_data=0x55; TAG_FREE -> ready=1, data=0.
//  Fill 16, retire 4, allocate 4 more -> tail wraps to 4; commit order is preserved across the wrap.
//  ROB_FLUSH_EN: tag0 mispredict, data=0x100, 3 younger entries -> commit tag0, flush=1, flush_pc=0x100, count=0.

Source files
------------

// File: rtl/reorder_buffer_p_pkg.sv
// Shared definitions for the reorder buffer: default geometry, tag layout
// and the retire decision encoding used by the top level.
package reorder_buffer_p_pkg;

    localparam int ROB_DEPTH  = 16;
    localparam int ROB_IDX_W  = 4;
    localparam int ROB_DATA_W = 32;
    localparam int ROB_REG_W  = 5;
    localparam int ROB_NCDB   = 3;

    // A tag is {free, index}; the MSB set means "no producer in flight".
    localparam int ROB_TAG_W  = ROB_IDX_W + 1;

    // What the head entry does at the next edge.
    typedef enum logic [1:0] {
        RET_NONE   = 2'd0,
        RET_COMMIT = 2'd1,
        RET_FLUSH  = 2'd2
    } retire_e;

endpackage

// File: rtl/reorder_buffer_p_if.sv
// Bundles the decoder, CDB and commit-side signals of the reorder buffer.
// The master side is whoever feeds the buffer; the slave side is the buffer.
interface reorder_buffer_p_if
    import reorder_buffer_p_pkg::*;
#(
    parameter int IDX_W  = ROB_IDX_W,
    parameter int DATA_W = ROB_DATA_W,
    parameter int REG_W  = ROB_REG_W,
    parameter int NCDB   = ROB_NCDB
);
    localparam int TAG_W = IDX_W + 1;

    logic                     alloc_valid;
    logic [REG_W-1:0]         alloc_rd;
    logic                     alloc_ready;
    logic [TAG_W-1:0]         alloc_tag;

    logic [TAG_W-1:0]         src1_tag;
    logic [TAG_W-1:0]         src2_tag;
    logic                     src1_ready;
    logic [DATA_W-1:0]        src1_data;
    logic                     src2_ready;
    logic [DATA_W-1:0]        src2_data;

    logic [NCDB-1:0]          cdb_valid;
    logic [NCDB*TAG_W-1:0]    cdb_tag;
    logic [NCDB*DATA_W-1:0]   cdb_data;
    logic [NCDB-1:0]          cdb_mispredict;

    logic                     commit_valid;
    logic [REG_W-1:0]         commit_rd;
    logic [DATA_W-1:0]        commit_data;
    logic [TAG_W-1:0]         commit_tag;
    logic                     flush;
    logic [DATA_W-1:0]        flush_pc;
    logic [TAG_W-1:0]         rob_count;

    modport master (
        output alloc_valid, alloc_rd, src1_tag, src2_tag,
               cdb_valid, cdb_tag, cdb_data, cdb_mispredict,
        input  alloc_ready, alloc_tag, src1_ready, src1_data, src2_ready, src2_data,
               commit_valid, commit_rd, commit_data, commit_tag, flush, flush_pc, rob_count
    );

    modport slave (
        input  alloc_valid, alloc_rd, src1_tag, src2_tag,
               cdb_valid, cdb_tag, cdb_data, cdb_mispredict,
        output alloc_ready, alloc_tag, src1_ready, src1_data, src2_ready, src2_data,
               commit_valid, commit_rd, commit_data, commit_tag, flush, flush_pc, rob_count
    );

endinterface

// File: rtl/reorder_buffer_p_src_lookup.sv
// Operand lookup for one decoder source: resolves a tag to ready/data using,
// in priority order, the free encoding, a same-cycle CDB broadcast (lowest
// port wins), and finally the value already stored in the buffer.
module reorder_buffer_p_src_lookup #(
    parameter int TAG_W  = 5,
    parameter int DATA_W = 32,
    parameter int NCDB   = 3
) (
    input  logic [TAG_W-1:0]       tag,
    input  logic [NCDB-1:0]        cdb_valid,
    input  logic [NCDB*TAG_W-1:0]  cdb_tag,
    input  logic [NCDB*DATA_W-1:0] cdb_data,
    input  logic                   stored_ready,
    input  logic [DATA_W-1:0]      stored_data,
    output logic                   ready,
    output logic [DATA_W-1:0]      data
);

    // Walk ports from highest to lowest so the lowest matching port overrides; free tags beat everything.
    always_comb begin
        ready = stored_ready;
        data  = stored_data;
        for (int p = NCDB - 1; p >= 0; p--) begin
            if (cdb_valid[p] && (cdb_tag[p*TAG_W +: TAG_W] == tag)) begin
                ready = 1'b1;
                data  = cdb_data[p*DATA_W +: DATA_W];
            end
        end
        if (tag[TAG_W-1]) begin
            ready = 1'b1;
            data  = '0;
        end
    end

endmodule

// File: rtl/reorder_buffer_p.sv
// Reorder buffer: in-order allocation from the decoder, out-of-order result
// capture from NCDB broadcast buses, in-order retirement of one entry per cycle.
// Optional feature macro ROB_FLUSH_EN: retiring a mispredicted branch raises a
// one-cycle flush with the redirect target and empties the buffer.
module reorder_buffer_p
    import reorder_buffer_p_pkg::*;
#(
    parameter int DEPTH  = ROB_DEPTH,
    parameter int IDX_W  = $clog2(DEPTH),
    parameter int DATA_W = ROB_DATA_W,
    parameter int REG_W  = ROB_REG_W,
    parameter int NCDB   = ROB_NCDB
) (
    input  logic              clk,
    input  logic              rst,
    reorder_buffer_p_if.slave bus
);

    localparam int TAG_W = IDX_W + 1;
    localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(DEPTH);

    logic [DEPTH-1:0]   ent_valid;
    logic [DEPTH-1:0]   ent_ready;
    logic [REG_W-1:0]   ent_rd   [DEPTH];
    logic [DATA_W-1:0]  ent_data [DEPTH];
`ifdef ROB_FLUSH_EN
    logic [DEPTH-1:0]   ent_mispred;
    logic               flush_q;
    logic [DATA_W-1:0]  flush_pc_q;
`else
    logic               unused_mispredict;
`endif

    logic [IDX_W-1:0]   head;
    logic [IDX_W-1:0]   tail;
    logic [IDX_W:0]     count;
    logic [IDX_W:0]     count_next;

    logic               do_alloc;
    logic               do_retire;
    retire_e            retire_kind;

    logic [NCDB-1:0]    cdb_wr;
    logic [IDX_W-1:0]   cdb_idx [NCDB];

    logic               commit_valid_q;
    logic [REG_W-1:0]   commit_rd_q;
    logic [DATA_W-1:0]  commit_data_q;
    logic [TAG_W-1:0]   commit_tag_q;

    logic [IDX_W-1:0]   src1_idx;
    logic [IDX_W-1:0]   src2_idx;
    logic               src1_ready;
    logic               src2_ready;
    logic [DATA_W-1:0]  src1_data;
    logic [DATA_W-1:0]  src2_data;

    // Decide allocation and what the head entry does this cycle; free slots count only from the current occupancy.
    always_comb begin
        do_alloc    = bus.alloc_valid && (count != FULL_CNT);
        retire_kind = RET_NONE;
        if ((count != '0) && ent_valid[head] && ent_ready[head]) begin
            retire_kind = RET_COMMIT;
`ifdef ROB_FLUSH_EN
            if (ent_mispred[head]) begin
                retire_kind = RET_FLUSH;
            end
`endif
        end
        do_retire = (retire_kind != RET_NONE);
        case ({do_alloc, do_retire})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Decode which CDB ports actually land: a real tag that names a live entry.
    always_comb begin
        cdb_wr = '0;
        for (int p = 0; p < NCDB; p++) begin
            cdb_idx[p] = bus.cdb_tag[p*TAG_W +: IDX_W];
            cdb_wr[p]  = bus.cdb_valid[p] && !bus.cdb_tag[p*TAG_W + IDX_W] && ent_valid[cdb_idx[p]];
        end
    end

    // Entry storage, pointers and the registered commit/flush outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid      <= '0;
            ent_ready      <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_data_q  <= '0;
            commit_tag_q   <= '0;
`ifdef ROB_FLUSH_EN
            ent_mispred    <= '0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
`endif
        end else begin
            commit_valid_q <= do_retire;
            if (do_retire) begin
                commit_rd_q   <= ent_rd[head];
                commit_data_q <= ent_data[head];
                commit_tag_q  <= {1'b0, head};
            end
`ifdef ROB_FLUSH_EN
            flush_q    <= (retire_kind == RET_FLUSH);
            flush_pc_q <= (retire_kind == RET_FLUSH) ? ent_data[head] : '0;
`endif
            if (retire_kind == RET_FLUSH) begin
                ent_valid <= '0;
                ent_ready <= '0;
                head      <= '0;
                tail      <= '0;
                count     <= '0;
            end else begin
                if (do_alloc) begin
                    ent_valid[tail] <= 1'b1;
                    ent_ready[tail] <= 1'b0;
                    ent_rd[tail]    <= bus.alloc_rd;
                    ent_data[tail]  <= '0;
`ifdef ROB_FLUSH_EN
                    ent_mispred[tail] <= 1'b0;
`endif
                    tail <= tail + 1'b1;
                end
                for (int p = NCDB - 1; p >= 0; p--) begin
                    if (cdb_wr[p]) begin
                        ent_ready[cdb_idx[p]] <= 1'b1;
                        ent_data[cdb_idx[p]]  <= bus.cdb_data[p*DATA_W +: DATA_W];
`ifdef ROB_FLUSH_EN
                        ent_mispred[cdb_idx[p]] <= bus.cdb_mispredict[p];
`endif
                    end
                end
                if (do_retire) begin
                    ent_valid[head] <= 1'b0;
                    ent_ready[head] <= 1'b0;
                    head            <= head + 1'b1;
                end
                count <= count_next;
            end
        end
    end

    assign src1_idx = bus.src1_tag[IDX_W-1:0];
    assign src2_idx = bus.src2_tag[IDX_W-1:0];

    reorder_buffer_p_src_lookup #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .NCDB   (NCDB)
    ) u_src1 (
        .tag          (bus.src1_tag),
        .cdb_valid    (bus.cdb_valid),
        .cdb_tag      (bus.cdb_tag),
        .cdb_data     (bus.cdb_data),
        .stored_ready (ent_valid[src1_idx] && ent_ready[src1_idx]),
        .stored_data  (ent_data[src1_idx]),
        .ready        (src1_ready),
        .data         (src1_data)
    );

    reorder_buffer_p_src_lookup #(
        .TAG_W  (TAG_W),
        .DATA_W (DATA_W),
        .NCDB   (NCDB)
    ) u_src2 (
        .tag          (bus.src2_tag),
        .cdb_valid    (bus.cdb_valid),
        .cdb_tag      (bus.cdb_tag),
        .cdb_data     (bus.cdb_data),
        .stored_ready (ent_valid[src2_idx] && ent_ready[src2_idx]),
        .stored_data  (ent_data[src2_idx]),
        .ready        (src2_ready),
        .data         (src2_data)
    );

    assign bus.alloc_ready  = (count != FULL_CNT);
    assign bus.alloc_tag    = {1'b0, tail};
    assign bus.rob_count    = count;
    assign bus.src1_ready   = src1_ready;
    assign bus.src1_data    = src1_data;
    assign bus.src2_ready   = src2_ready;
    assign bus.src2_data    = src2_data;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_rd    = commit_rd_q;
    assign bus.commit_data  = commit_data_q;
    assign bus.commit_tag   = commit_tag_q;
`ifdef ROB_FLUSH_EN
    assign bus.flush        = flush_q;
    assign bus.flush_pc     = flush_pc_q;
`else
    assign bus.flush        = 1'b0;
    assign bus.flush_pc     = '0;
    assign unused_mispredict = ^bus.cdb_mispredict;
`endif

endmodule
